// File: rtl/pigasus_sme_pkg.sv
// Shared types and trailer layout for the Pigasus string-matching match collector.
package pigasus_sme_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_TRAILER
  } sme_state_e;

  // A rule-ID slot holding this value carries no match.
  localparam int unsigned RULE_ID_NONE = 0;

  // Trailer word at the default rule-ID width: overflow flag in the top bit,
  // match count in the bits below it.
  localparam int unsigned SME_ID_W = 16;
  localparam int unsigned OVF_BIT  = SME_ID_W - 1;

  // Overflow bit position, which is also the count field width, for any ID width.
  function automatic int unsigned ovf_bit(input int unsigned id_w);
    return id_w - 1;
  endfunction

endpackage

// File: rtl/lane_pri_sel.sv
// Lowest-set-bit finder over the pending-lane mask of the match collector.
module lane_pri_sel #(
  parameter int unsigned LANES = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [LANES-1:0] mask_i,
  output logic [LANES-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             single_o,
  output logic             any_o
);

  // Isolate the lowest set bit and encode its position.
  always_comb begin
    onehot_o = mask_i & (~mask_i + LANES'(1));
    idx_o    = '0;
    for (int unsigned i = LANES; i > 0; i--) begin
      if (mask_i[i-1]) idx_o = IDX_W'(i - 1);
    end
    any_o    = |mask_i;
    single_o = any_o && ((mask_i & (mask_i - LANES'(1))) == '0);
  end

endmodule

// File: rtl/sme_match_collector.sv
// Serialises per-packet non-zero rule IDs from port_group beats into one ID per
// cycle, with optional back-to-back dedup, a match cap and a count/overflow trailer.
module sme_match_collector
  import pigasus_sme_pkg::*;
#(
  parameter int unsigned LANES       = 8,
  parameter int unsigned ID_W        = 16,
  parameter int unsigned MAX_MATCHES = 32,
  parameter int unsigned DEDUP       = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LANES*ID_W-1:0] s_rule_data,
  input  logic                 s_rule_valid,
  output logic                 s_rule_ready,
  input  logic                 s_rule_sop,
  input  logic                 s_rule_eop,
  input  logic [3:0]           s_rule_empty,
  output logic [ID_W-1:0]      m_match_data,
  output logic                 m_match_valid,
  input  logic                 m_match_ready,
  output logic                 m_match_last
);

  localparam int unsigned CNT_W = ovf_bit(ID_W);
  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_MATCHES);

  sme_state_e       state_q, state_d;
  logic [ID_W-1:0]  ids_q [LANES];
  logic [ID_W-1:0]  ids_d [LANES];
  logic [LANES-1:0] mask_q, mask_d, new_mask;
  logic             eop_q, eop_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [ID_W-1:0]  last_id_q, last_id_d;
  logic             in_pkt_q, in_pkt_d;
  logic             rdy_en_q;

  logic [LANES-1:0] head_oh;
  logic [IDX_W-1:0] head_idx;
  logic             head_single, head_any;
  logic [ID_W-1:0]  head_id;
  logic             at_cap, dup, drain_done, load;

  // Empty count is redundant: zero lanes already mean no match.
  logic unused_empty;
  assign unused_empty = ^s_rule_empty;

  lane_pri_sel #(
    .LANES(LANES),
    .IDX_W(IDX_W)
  ) u_pri_sel (
    .mask_i   (mask_q),
    .onehot_o (head_oh),
    .idx_o    (head_idx),
    .single_o (head_single),
    .any_o    (head_any)
  );

  assign head_id = ids_q[head_idx];

  // Next-state, output decode and beat loading; outputs depend only on held state
  // (plus downstream ready for the overlap accept).
  always_comb begin
    state_d       = state_q;
    ids_d         = ids_q;
    mask_d        = mask_q;
    eop_d         = eop_q;
    count_d       = count_q;
    ovf_d         = ovf_q;
    last_id_d     = last_id_q;
    in_pkt_d      = in_pkt_q;
    new_mask      = '0;
    s_rule_ready  = 1'b0;
    m_match_valid = 1'b0;
    m_match_last  = 1'b0;
    m_match_data  = '0;
    at_cap        = (count_q == CNT_MAX);
    dup           = (DEDUP != 0) && (head_id == last_id_q);
    drain_done    = 1'b0;
    load          = 1'b0;

    case (state_q)
      ST_IDLE: s_rule_ready = rdy_en_q;
      ST_DRAIN: begin
        if (!head_any) begin
          drain_done = 1'b1;
        end else if (at_cap) begin
          ovf_d      = 1'b1;
          mask_d     = '0;
          drain_done = 1'b1;
        end else if (dup) begin
          mask_d     = mask_q & ~head_oh;
          drain_done = head_single;
        end else begin
          m_match_valid = 1'b1;
          m_match_data  = head_id;
          if (m_match_ready) begin
            mask_d     = mask_q & ~head_oh;
            count_d    = count_q + CNT_W'(1);
            last_id_d  = head_id;
            drain_done = head_single;
          end
        end
        if (drain_done) state_d = eop_q ? ST_TRAILER : ST_IDLE;
        // Accepting the next beat as the last pending ID leaves avoids a bubble.
        s_rule_ready = drain_done && !eop_q && rdy_en_q;
      end
      ST_TRAILER: begin
        m_match_valid = 1'b1;
        m_match_last  = 1'b1;
        m_match_data  = {ovf_q, count_q};
        if (m_match_ready) begin
          in_pkt_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Beats outside a packet are swallowed until a sop arrives.
    load = s_rule_valid && s_rule_ready && (s_rule_sop || in_pkt_q);
    if (load) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        ids_d[i]    = s_rule_data[i*ID_W +: ID_W];
        new_mask[i] = (s_rule_data[i*ID_W +: ID_W] != ID_W'(RULE_ID_NONE));
      end
      mask_d = new_mask;
      eop_d  = s_rule_eop;
      if (s_rule_sop) begin
        count_d   = '0;
        ovf_d     = 1'b0;
        last_id_d = '0;
        in_pkt_d  = 1'b1;
      end
      if (new_mask != '0)  state_d = ST_DRAIN;
      else if (s_rule_eop) state_d = ST_TRAILER;
      else                 state_d = ST_IDLE;
    end
  end

  // Control state with synchronous reset; ready is held off for one cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      eop_q     <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      last_id_q <= '0;
      in_pkt_q  <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      eop_q     <= eop_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      last_id_q <= last_id_d;
      in_pkt_q  <= in_pkt_d;
      rdy_en_q  <= 1'b1;
    end
  end

  // Hold-register ID slots; only meaningful where the mask bit is set.
  always_ff @(posedge clk) begin
    ids_q <= ids_d;
  end

endmodule

// File: doc/sme_match_collector.md
Name: sme_match_collector

Overview:
- Downstream of the port_group stage in the Pigasus string-matching pipeline.
- Consumes port_group beats: LANES x ID_W rule-ID slots per beat, where 0 means no match.
- Per packet, compacts non-zero rule IDs into a serial stream of one ID per cycle. Drops back-to-back duplicates, caps the match count, and closes each packet with a trailer word carrying the match count and an overflow flag. Feeds the core-side match FIFO / descriptor writer.

Parameters:
- LANES, 8, rule-ID slots per input beat
- ID_W, 16, rule-ID width; trailer word uses the same width
- MAX_MATCHES, 32, IDs emitted per packet before truncation (≤ 2^(ID_W-1)-1)
- DEDUP, 1, 1 = suppress an ID equal to the previous emitted ID of the same packet

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_rule_data  in  LANES*ID_W  lane i = bits [i*ID_W +: ID_W]
- s_rule_valid  in  1  beat valid
- s_rule_ready  out  1  beat accepted when valid&ready
- s_rule_sop  in  1  first beat of packet
- s_rule_eop  in  1  last beat of packet
- s_rule_empty  in  4  ignored; zero lanes already mean no match
- m_match_data  out  ID_W  rule ID, or trailer {overflow, count[ID_W-2:0]}
- m_match_valid  out  1  output valid
- m_match_ready  in  1  downstream ready
- m_match_last  out  1  marks the trailer word; one per packet

Behaviour:
- Reset: rst synchronous, active-high, clock clk.
  - All outputs reset to 0; s_rule_ready resets to 1 the cycle after reset deasserts.
  - Pending mask, count, overflow, last_id, in_pkt and state are cleared.
  - Reset mid-packet: the partial packet is lost with no trailer. Beats are discarded (ready=1, ignored) until a beat with sop.
- Hold register: holds ids[LANES], mask[LANES], eop_h.
  - On accept, mask[i] = (id[i] != 0).
  - On accept with sop: count=0, overflow=0, last_id=0, in_pkt=1. A sop arriving while in_pkt=1 implicitly starts a new packet; no trailer is emitted for the old one.
- States: IDLE, DRAIN, TRAILER.
- IDLE:
  - s_rule_ready=1.
  - Accepted beat with mask≠0 → DRAIN.
  - Accepted beat with mask==0 and eop → TRAILER.
  - Otherwise stay in IDLE.
- DRAIN: head = lowest set bit of mask.
  - count==MAX_MATCHES:
    - overflow=1 and the whole mask is cleared in one cycle.
    - No output that cycle.
  - DEDUP and ids[head]==last_id:
    - The head bit is cleared and m_match_valid=0 that cycle (one-cycle bubble).
  - Otherwise:
    - m_match_valid=1, m_match_data=ids[head], m_match_last=0.
    - On handshake: clear the head bit, count+=1, last_id=ids[head].
  - When the last set bit clears: go to TRAILER if eop_h, else IDLE.
- DRAIN next-beat overlap (no bubble between beats):
  - s_rule_ready=1 in DRAIN when the clearing bit is the only set bit and eop_h=0.
  - An accepted beat then loads directly and the block stays in DRAIN, or goes to IDLE if the new mask is 0.
- TRAILER:
  - m_match_valid=1, m_match_last=1, m_match_data = {overflow, count zero-extended}.
  - s_rule_ready=0.
  - On handshake: in_pkt=0, go to IDLE.
- Latency and throughput:
  - First ID is visible the cycle after the beat is accepted.
  - Sustained rate is 1 output per cycle; an input beat with k emitted IDs costs max(1,k) cycles.
- Output protocol:
  - m_match_data, m_match_valid and m_match_last stay stable while valid && !ready.
  - Outputs are driven from the hold register, with no combinational path from s_rule_data.
- Width rules: count saturates at MAX_MATCHES; overflow is sticky per packet.

Decomposition:
- pigasus_sme_pkg holds:
  - the state enum {IDLE, DRAIN, TRAILER}
  - localparams for the trailer field layout (OVF_BIT = ID_W-1)
  - RULE_ID_NONE = 0
- Sub-module lane_pri_sel (LANES): combinational lowest-set-bit finder. Outputs a one-hot vector, a binary index, a "single bit set" flag and an any flag.

Test Plan:
- Single-beat packet, sop+eop, lanes {0:0x0012, 3:0x0345, 7:0x0678}, ready=1 → outputs 0x0012, 0x0345, 0x0678, then trailer 0x0003 with last=1; 4 output cycles.
- Two-beat packet: beat 0 lane 5=0x00AA; beat 1 (eop) lanes 0=0x00AA, 1=0x00BB.
  - DEDUP=1 → 0x00AA, 0x00BB, trailer 0x0002.
  - DEDUP=0 → 0x00AA, 0x00AA, 0x00BB, trailer 0x0003.
- Packet with all lanes zero over 3 beats → only trailer 0x0000 with last=1; s_rule_ready never deasserts before eop.
- MAX_MATCHES=4, one beat with 8 distinct non-zero IDs → 4 IDs, then trailer 0x8004.
- Backpressure: m_match_ready toggles 1010… during a 3-match beat → every ID held stable while stalled, no loss or duplication, s_rule_ready low until the final ID handshake.
- rst asserted while in DRAIN of packet A; then a non-sop beat, then a packet B single beat with lane 2=0x0042 → nothing output for A or for the non-sop beat; B yields 0x0042, then trailer 0x0001.
